// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction-fetch, data-stage and main-memory signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  logic        mm_enable;
  logic [31:0] mm_address;
  logic [64:0] mm_edit_serial;
  logic [31:0] mm_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mm_rdata,
    output if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           mm_enable, mm_address, mm_edit_serial, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mm_rdata,
    input  if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           mm_enable, mm_address, mm_edit_serial, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-stage requests onto a single main-memory port,
// one command at a time. Define ARB_STARVE_GUARD_EN to bound how long IF can be starved.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               CLK,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state_reg;
  logic        cmd_mem_reg;
  logic        cmd_we_reg;
  logic        we_issue_reg;
  logic [29:0] cmd_word_reg;
  logic [31:0] cmd_wdata_reg;
  logic [3:0]  wait_cnt_reg;
  logic        if_gnt_reg;
  logic        mem_gnt_reg;
  logic        if_valid_reg;
  logic        mem_valid_reg;
  logic        mm_enable_reg;
  logic        busy_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] mem_rdata_reg;

  logic arb_point;
  logic pick_mem;
  logic pick_if;

  assign arb_point = (state_reg == IDLE) || (state_reg == RESP);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg;
  logic       starve_hit;

  // IF overrides MEM once MEM has won STARVE_LIMIT times in a row while IF was waiting.
  assign starve_hit = (starve_cnt_reg == STARVE_MAX);
  assign pick_if    = bus.if_req && (!bus.mem_req || starve_hit);
  assign pick_mem   = bus.mem_req && !pick_if;

  always_ff @(posedge CLK) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (arb_point) begin
      if (!bus.if_req || pick_if) begin
        starve_cnt_reg <= '0;
      end else if (pick_mem) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end
`else
  assign pick_mem = bus.mem_req;
  assign pick_if  = bus.if_req && !bus.mem_req;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= IDLE;
      cmd_mem_reg   <= 1'b0;
      cmd_we_reg    <= 1'b0;
      we_issue_reg  <= 1'b0;
      cmd_word_reg  <= '0;
      cmd_wdata_reg <= '0;
      wait_cnt_reg  <= '0;
      if_gnt_reg    <= 1'b0;
      mem_gnt_reg   <= 1'b0;
      if_valid_reg  <= 1'b0;
      mem_valid_reg <= 1'b0;
      mm_enable_reg <= 1'b0;
      busy_reg      <= 1'b0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      if_gnt_reg    <= 1'b0;
      mem_gnt_reg   <= 1'b0;
      if_valid_reg  <= 1'b0;
      mem_valid_reg <= 1'b0;
      we_issue_reg  <= 1'b0;
      if (arb_point) begin
        if (pick_mem || pick_if) begin
          state_reg     <= ISSUE;
          cmd_mem_reg   <= pick_mem;
          cmd_we_reg    <= pick_mem && bus.mem_we;
          we_issue_reg  <= pick_mem && bus.mem_we;
          cmd_word_reg  <= pick_mem ? bus.mem_addr[31:2] : bus.if_addr[31:2];
          cmd_wdata_reg <= pick_mem ? bus.mem_wdata : 32'd0;
          mem_gnt_reg   <= pick_mem;
          if_gnt_reg    <= pick_if;
          mm_enable_reg <= 1'b1;
          busy_reg      <= 1'b1;
        end else begin
          state_reg     <= IDLE;
          mm_enable_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      end else if (state_reg == ISSUE) begin
        state_reg    <= WAIT;
        wait_cnt_reg <= WAIT_LOAD;
      end else if (wait_cnt_reg == 4'd0) begin
        // Last WAIT cycle: mm_rdata is valid now, so capture it for reads.
        state_reg     <= RESP;
        mm_enable_reg <= 1'b0;
        busy_reg      <= 1'b0;
        mem_valid_reg <= cmd_mem_reg;
        if_valid_reg  <= !cmd_mem_reg;
        if (!cmd_we_reg) begin
          if (cmd_mem_reg) begin
            mem_rdata_reg <= bus.mm_rdata;
          end else begin
            if_rdata_reg <= bus.mm_rdata;
          end
        end
      end else begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end
    end
  end

  assign bus.if_gnt         = if_gnt_reg;
  assign bus.mem_gnt        = mem_gnt_reg;
  assign bus.if_valid       = if_valid_reg;
  assign bus.mem_valid      = mem_valid_reg;
  assign bus.if_rdata       = if_rdata_reg;
  assign bus.mem_rdata      = mem_rdata_reg;
  assign bus.mm_enable      = mm_enable_reg;
  assign bus.busy           = busy_reg;
  assign bus.mm_address     = {2'b00, cmd_word_reg};
  // The write strobe is masked by reset so a write caught in ISSUE at a reset edge never lands.
  assign bus.mm_edit_serial = {we_issue_reg & ~reset, 2'b00, cmd_word_reg, cmd_wdata_reg};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-1 instance under directed and random traffic,
// plus a latency-3 instance for long-latency timing and reset-abort cases.
module tb_mem_port_arbiter;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
  localparam int STARVE = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, mem_load, mon_en;
  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LATENCY(LAT_A), .STARVE_LIMIT(STARVE)) u_dut_a (
    .CLK(clk), .reset(rst_a), .bus(bus_a));
  mem_port_arbiter #(.MEM_LATENCY(LAT_B), .STARVE_LIMIT(STARVE)) u_dut_b (
    .CLK(clk), .reset(rst_b), .bus(bus_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [71:0] act, logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0103;
  endfunction

  // Memory devices: data is presented only in the cycle exactly LAT cycles after issue.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int age_a, age_b;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
      age_a <= 0;
      age_b <= 0;
    end else begin
      if (bus_a.mm_enable && bus_a.mm_edit_serial[64])
        mem_a[bus_a.mm_address[7:0]] <= bus_a.mm_edit_serial[31:0];
      if (bus_b.mm_enable && bus_b.mm_edit_serial[64])
        mem_b[bus_b.mm_address[7:0]] <= bus_b.mm_edit_serial[31:0];
      age_a <= bus_a.mm_enable ? age_a + 1 : 0;
      age_b <= bus_b.mm_enable ? age_b + 1 : 0;
    end
  end
  assign bus_a.mm_rdata = (bus_a.mm_enable && age_a == LAT_A) ? mem_a[bus_a.mm_address[7:0]] : 32'hA5A5_5A5A;
  assign bus_b.mm_rdata = (bus_b.mm_enable && age_b == LAT_B) ? mem_b[bus_b.mm_address[7:0]] : 32'h5A5A_A5A5;

  // Reference model: flat word array plus a queue of expected responses in grant order.
  typedef struct {
    bit          is_mem;
    bit          rd;
    logic [31:0] data;
    int          vcyc;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  int          starve_m;
  int          last_gnt;
  logic        ireq_s, mreq_s;
  bit          exp_mem_win, exp_en;

  task automatic if_txn(input logic [31:0] addr, output int waited);
    bus_a.if_addr = addr;
    bus_a.if_req  = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!bus_a.if_gnt && waited < 300);
    if (!bus_a.if_gnt) begin
      chk("if_gnt_timeout", bus_a.if_gnt, 1);
    end else begin
      chk("if_issue_bus", {bus_a.mm_enable, bus_a.mm_edit_serial[64:32]}, {1'b1, 1'b0, 2'b00, addr[31:2]});
      sb.push_back('{1'b0, 1'b1, ref_mem[addr[9:2]], cyc + 1 + LAT_A});
    end
    @(posedge clk);
    #1;
    bus_a.if_req  = 1'b0;
    bus_a.if_addr = $urandom;
  endtask

  task automatic mem_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, output int waited);
    bus_a.mem_we    = we;
    bus_a.mem_addr  = addr;
    bus_a.mem_wdata = wdata;
    bus_a.mem_req   = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end while (!bus_a.mem_gnt && waited < 300);
    if (!bus_a.mem_gnt) begin
      chk("mem_gnt_timeout", bus_a.mem_gnt, 1);
    end else begin
      chk("mem_issue_bus", {bus_a.mm_enable, bus_a.mm_edit_serial}, {1'b1, we, 2'b00, addr[31:2], wdata});
      if (we) begin
        ref_mem[addr[9:2]] = wdata;
        sb.push_back('{1'b1, 1'b0, 32'd0, cyc + 1 + LAT_A});
      end else begin
        sb.push_back('{1'b1, 1'b1, ref_mem[addr[9:2]], cyc + 1 + LAT_A});
      end
    end
    @(posedge clk);
    #1;
    bus_a.mem_req   = 1'b0;
    bus_a.mem_we    = 1'($urandom);
    bus_a.mem_addr  = $urandom;
    bus_a.mem_wdata = $urandom;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, 72'(sb.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    ireq_s <= bus_a.if_req;
    mreq_s <= bus_a.mem_req;
  end

  // Monitor for the latency-1 instance.
  always @(negedge clk) begin
    if (rst_a) begin
      exp_if_rdata  = '0;
      exp_mem_rdata = '0;
      starve_m      = 0;
      last_gnt      = -100;
    end else if (mon_en) begin
      chk("single_gnt", bus_a.if_gnt & bus_a.mem_gnt, 0);
      if (bus_a.if_gnt || bus_a.mem_gnt) begin
        exp_mem_win = mreq_s && !(GUARD && ireq_s && starve_m >= STARVE);
        chk("gnt_winner", {bus_a.mem_gnt, bus_a.if_gnt}, exp_mem_win ? 2'b10 : 2'b01);
        if (bus_a.if_gnt) starve_m = 0;
        else starve_m = ireq_s ? starve_m + 1 : 0;
        last_gnt = cyc;
      end else begin
        chk("we_outside_issue", bus_a.mm_edit_serial[64], 0);
      end
      exp_en = (cyc - last_gnt) <= LAT_A;
      chk("mm_enable", bus_a.mm_enable, exp_en);
      chk("busy", bus_a.busy, exp_en);
      if (bus_a.if_valid || bus_a.mem_valid) begin
        if (sb.size() == 0) begin
          chk("valid_expected", {bus_a.mem_valid, bus_a.if_valid}, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("valid_port", {bus_a.mem_valid, bus_a.if_valid}, mon_e.is_mem ? 2'b10 : 2'b01);
          chk("valid_cycle", 72'(cyc), 72'(mon_e.vcyc));
          if (mon_e.rd) begin
            if (mon_e.is_mem) exp_mem_rdata = mon_e.data;
            else exp_if_rdata = mon_e.data;
          end
        end
      end
      chk("if_rdata", bus_a.if_rdata, exp_if_rdata);
      chk("mem_rdata", bus_a.mem_rdata, exp_mem_rdata);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int iw, mw;
    mon_en   = 1'b0;
    mem_load = 1'b1;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus_a.if_req = 1'b1;  bus_a.if_addr = 32'h10;
    bus_a.mem_req = 1'b1; bus_a.mem_we = 1'b1; bus_a.mem_addr = 32'h20; bus_a.mem_wdata = 32'h1;
    bus_b.if_req = 1'b0;  bus_b.if_addr = 32'h0;
    bus_b.mem_req = 1'b0; bus_b.mem_we = 1'b0; bus_b.mem_addr = 32'h0; bus_b.mem_wdata = 32'h0;

    // Reset wins over requests held high at the same edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ctrl", {bus_a.if_gnt, bus_a.if_valid, bus_a.mem_gnt, bus_a.mem_valid, bus_a.mm_enable, bus_a.busy}, 0);
    chk("rst_a_rdata", {bus_a.if_rdata, bus_a.mem_rdata}, 0);
    chk("rst_a_mm", {bus_a.mm_address, bus_a.mm_edit_serial[64]}, 0);
    chk("rst_b_ctrl", {bus_b.if_gnt, bus_b.if_valid, bus_b.mem_gnt, bus_b.mem_valid, bus_b.mm_enable, bus_b.busy}, 0);
    bus_a.if_req  = 1'b0;
    bus_a.mem_req = 1'b0;
    mem_load      = 1'b0;
    @(posedge clk);
    #1;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // IF read of word 4 on an idle arbiter.
    if_txn(32'h0000_0010, iw);
    chk("if_read_gnt_wait", 72'(iw), 1);
    drain("if_read");
    chk("if_read_data", bus_a.if_rdata, 32'hDEAD_BEEF);

    // MEM write then read-back of the same word.
    mem_txn(1'b1, 32'h20, 32'h1234_5678, mw);
    mem_txn(1'b0, 32'h20, 32'h0, mw);
    drain("mem_wr_rd");
    chk("mem_readback", bus_a.mem_rdata, 32'h1234_5678);

    // Simultaneous requests: MEM first, IF issued right after the MEM response cycle.
    fork
      mem_txn(1'b0, 32'h40, 32'h0, mw);
      if_txn(32'h44, iw);
    join
    chk("collide_mem_wait", 72'(mw), 1);
    chk("collide_if_wait", 72'(iw), 4);
    drain("collide");

    // Randomized concurrent traffic from both requesters.
    fork
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          if_txn($urandom, iw);
        end
      end
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          mem_txn(1'($urandom_range(0, 1)), $urandom, $urandom, mw);
        end
      end
    join
    drain("random");

    // MEM requests back to back for six accesses while IF holds its request.
    fork
      repeat (6) mem_txn(1'b0, $urandom, 32'h0, mw);
      if_txn(32'h80, iw);
    join
    chk("starve_if_wait", 72'(iw), GUARD ? 72'd13 : 72'd19);
    drain("starve");

    // Latency-3 instance: IF read timing.
    bus_b.if_addr = 32'h10;
    bus_b.if_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_if_gnt", bus_b.if_gnt, k == 1);
      chk("b_mm_enable", bus_b.mm_enable, k <= 4);
      chk("b_if_valid", bus_b.if_valid, k == 5);
      if (k == 1) begin
        chk("b_mm_address", bus_b.mm_address, 32'h4);
        bus_b.if_req = 1'b0;
      end
    end
    chk("b_if_rdata", bus_b.if_rdata, 32'hDEAD_BEEF);

    // Reset in the middle of WAIT abandons a MEM read.
    @(posedge clk);
    #1;
    bus_b.mem_addr = 32'h24;
    bus_b.mem_we   = 1'b0;
    bus_b.mem_req  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        chk("b_mem_gnt", bus_b.mem_gnt, 1);
        bus_b.mem_req = 1'b0;
      end
    end
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_rst_ctrl", {bus_b.if_gnt, bus_b.if_valid, bus_b.mem_gnt, bus_b.mem_valid, bus_b.mm_enable, bus_b.busy}, 0);
    chk("b_rst_mm", {bus_b.mm_address, bus_b.mm_edit_serial}, 0);
    chk("b_rst_rdata", {bus_b.if_rdata, bus_b.mem_rdata}, 0);
    rst_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_no_valid", {bus_b.if_valid, bus_b.mem_valid}, 0);
    end

    // Reset during ISSUE of a write: the write must not reach memory.
    @(posedge clk);
    #1;
    bus_b.mem_addr  = 32'h28;
    bus_b.mem_we    = 1'b1;
    bus_b.mem_wdata = 32'hCAFE_F00D;
    bus_b.mem_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_wr_gnt", bus_b.mem_gnt, 1);
    chk("b_wr_issue_we", bus_b.mm_edit_serial[64], 1);
    bus_b.mem_req = 1'b0;
    rst_b = 1'b1;
    #1;
    chk("b_we_suppressed", bus_b.mm_edit_serial[64], 0);
    @(posedge clk);
    @(negedge clk);
    chk("b_mem_untouched", mem_b[10], init_word(10));
    chk("b_wr_rst_enable", bus_b.mm_enable, 0);
    rst_b = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning cycles from issue to valid mm_rdata (legal 1..15).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive MEM grants tolerated while IF waits (legal 1..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req input 1, if_addr input 32: instruction-fetch read request and its byte address.
REQ-006 SHALL have ports if_gnt output 1, if_valid output 1, if_rdata output 32: IF grant pulse, response pulse and read data.
REQ-007 SHALL have ports mem_req input 1, mem_we input 1, mem_addr input 32, mem_wdata input 32: data-stage request, write flag, byte address and write data.
REQ-008 SHALL have ports mem_gnt output 1, mem_valid output 1, mem_rdata output 32: data-stage grant pulse, response pulse and read data.
REQ-009 SHALL have ports mm_enable output 1, mm_address output 32, mm_edit_serial output 65, mm_rdata input 32: main-memory port.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE or RESP.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP; arbitration occurs only at edges ending IDLE or RESP cycles.
REQ-012 SHALL, when any request is sampled in IDLE/RESP, latch the winner's address, we and wdata into a command register and enter ISSUE; otherwise enter IDLE.
REQ-013 SHALL give priority to MEM over IF when both are sampled high together.
REQ-014 SHALL assert the winner's gnt for exactly the ISSUE cycle; requesters hold req and operands stable until gnt, and the arbiter ignores req during ISSUE and WAIT.
REQ-015 SHALL drive mm_address = latched byte address >> 2 (word address, upper two bits zero) during ISSUE and WAIT.
REQ-016 SHALL drive mm_edit_serial = {write bit, mm_address, wdata}; write bit is latched we in ISSUE only and 0 in every other cycle; IF commands always have we = 0.
REQ-017 SHALL drive mm_enable = 1 during ISSUE and WAIT, 0 otherwise.
REQ-018 SHALL stay in WAIT for exactly MEM_LATENCY cycles via a down-counter loaded at ISSUE, then enter RESP.
REQ-019 SHALL load the winner's rdata register from mm_rdata at the edge ending the last WAIT cycle (reads only; writes leave rdata unchanged).
REQ-020 SHALL pulse the winner's valid for the single RESP cycle, for reads and writes alike; the other requester's valid stays 0.
REQ-021 SHALL hold if_rdata/mem_rdata stable between responses.
REQ-022 SHALL give end-to-end timing for a request first sampled at edge E0: gnt in cycle E0+1, valid in cycle E0+2+MEM_LATENCY; a back-to-back request sampled in RESP reaches ISSUE next cycle (one access per 2+MEM_LATENCY cycles).
REQ-023 SHALL never issue more than one outstanding memory command.

Reset
REQ-024 SHALL, when reset is high at an edge, enter IDLE, clear the command register, counters, if_rdata and mem_rdata to 0, and drive every gnt, valid, mm_enable and busy to 0; reset wins over any simultaneous request.
REQ-025 SHALL, on reset during ISSUE or WAIT, abandon the access with no valid pulse; a write in ISSUE at that edge is suppressed.

Configuration
REQ-026 SHALL, with macro ARB_STARVE_GUARD_EN defined, count consecutive MEM grants made while if_req is high, clear the count on an IF grant or when if_req is sampled low, and grant IF at the next arbitration once the count equals STARVE_LIMIT.
REQ-027 SHALL, without ARB_STARVE_GUARD_EN, use strict MEM priority, instantiate no starvation counter, and let IF wait indefinitely.

Verification
REQ-028 SHALL cover IF read: if_req, if_addr=0x0000_0010 at E0, MEM_LATENCY=1, memory word 4 = 0xDEADBEEF -> mm_address=4, if_gnt cycle 1, if_valid cycle 3, if_rdata=0xDEADBEEF.
REQ-029 SHALL cover MEM write: mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 -> mm_edit_serial={1, 0x8, 0x12345678} in ISSUE only, mem_valid one cycle, then MEM read of 0x20 returns 0x12345678.
REQ-030 SHALL cover collision: if_req and mem_req both high at E0 -> mem_gnt first; IF granted in the RESP cycle of the MEM access, if_gnt in cycle 4 for MEM_LATENCY=1.
REQ-031 SHALL cover starvation with ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both held high -> MEM granted 4 times, 5th grant to IF; without the macro, IF never granted.
REQ-032 SHALL cover reset mid-WAIT with MEM_LATENCY=3 -> no valid pulse, all outputs 0 next cycle, rdata registers 0.
REQ-033 SHALL cover MEM_LATENCY=3 IF read -> if_gnt cycle 1, mm_enable high cycles 1-4, if_valid cycle 5.
